// File: rtl/tlc1543_pkg.sv
// Shared constants for the TLC1543 device-side model: frame geometry, special
// addresses, FSM state encoding and the address-to-sample decode.
package tlc1543_pkg;

  localparam int FRAME_BITS = 10;
  localparam int ADDR_BITS  = 4;

  localparam logic [3:0] ADDR_REF_MID = 4'hB;
  localparam logic [3:0] ADDR_REF_LO  = 4'hC;
  localparam logic [3:0] ADDR_REF_HI  = 4'hD;
  localparam logic [3:0] ADDR_PWRDN   = 4'hE;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_WAIT_CS = 2'd3;

  typedef logic [FRAME_BITS-1:0] sample_t;

  // Channels 0..10 come from the input bus; the rest are fixed reference codes.
  function automatic sample_t decode_sample(input logic [3:0] addr, input logic [109:0] ain);
    int idx;
    idx = int'(addr);
    case (addr)
      ADDR_REF_MID: decode_sample = 10'h200;
      ADDR_REF_LO:  decode_sample = 10'h000;
      ADDR_REF_HI:  decode_sample = 10'h3FF;
      4'hE, 4'hF:   decode_sample = 10'h000;
      default:      decode_sample = ain[idx*10 +: 10];
    endcase
  endfunction

endpackage

// File: rtl/tlc1543_pin_sync.sv
// Two-flop synchronizer for one asynchronous pin, with an extra history flop
// to produce single-cycle rise/fall pulses.
module tlc1543_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/tlc1543_adc_model.sv
// Device-side TLC1543 responder: returns the previous conversion result while
// clocking in the next address, then runs a timed conversion with EOC low.
module tlc1543_adc_model
  import tlc1543_pkg::*;
#(
  parameter int CONV_CYCLES = 1050,
  parameter int NUM_AIN     = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10*NUM_AIN-1:0] ain_flat,
  input  logic                  tlc1543_clk,
  input  logic                  tlc1543_cs_n,
  input  logic                  tlc1543_addr,
  output logic                  tlc1543_data,
  output logic                  tlc1543_data_oe,
  output logic                  tlc1543_eoc,
  output logic                  conv_done,
  output logic [3:0]            last_addr
);

  localparam int CNT_W = $clog2(CONV_CYCLES);

  logic cs_sync, cs_rise, cs_fall;
  logic clk_rise, clk_fall, addr_sync;
  logic unused_clk_sync, unused_addr_rise, unused_addr_fall;

  tlc1543_pin_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .pin_i(tlc1543_cs_n),
    .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  tlc1543_pin_sync #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .pin_i(tlc1543_clk),
    .sync_o(unused_clk_sync), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  tlc1543_pin_sync #(.RESET_VAL(1'b0)) u_sync_addr (
    .clk(clk), .rst(rst), .pin_i(tlc1543_addr),
    .sync_o(addr_sync), .rise_o(unused_addr_rise), .fall_o(unused_addr_fall)
  );

  logic [1:0]       state_q, state_d;
  sample_t          shift_q, shift_d;
  sample_t          sample_q, sample_d;
  sample_t          result_q, result_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       addr_sr_q, addr_sr_d;
  logic [3:0]       last_addr_q, last_addr_d;
  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d;
  logic             data_q, data_d;
  logic             oe_q, oe_d;
  logic             eoc_q, eoc_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sample_d    = sample_q;
    result_d    = result_q;
    bit_cnt_d   = bit_cnt_q;
    addr_sr_d   = addr_sr_q;
    last_addr_d = last_addr_q;
    conv_cnt_d  = conv_cnt_q;
    data_d      = data_q;
    oe_d        = oe_q;
    eoc_d       = eoc_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          shift_d   = result_q;
          data_d    = result_q[FRAME_BITS-1];
          oe_d      = 1'b1;
          bit_cnt_d = '0;
          addr_sr_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (clk_rise && (bit_cnt_q < 4'(ADDR_BITS)))
            addr_sr_d = {addr_sr_q[2:0], addr_sync};
          if (clk_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            // The 10th fall closes the frame; the captured address selects what converts next.
            if (bit_cnt_q == 4'(FRAME_BITS-1)) begin
              data_d      = 1'b0;
              last_addr_d = addr_sr_q;
              if (addr_sr_q == ADDR_PWRDN) begin
                state_d = ST_WAIT_CS;
              end else begin
                sample_d   = decode_sample(addr_sr_q, ain_flat);
                eoc_d      = 1'b0;
                conv_cnt_d = '0;
                state_d    = ST_CONVERT;
              end
            end else begin
              shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
              data_d  = shift_q[FRAME_BITS-2];
            end
          end
        end
      end

      ST_CONVERT: begin
        oe_d   = ~cs_sync;
        data_d = 1'b0;
        if (conv_cnt_q == CNT_W'(CONV_CYCLES-1)) begin
          result_d = sample_q;
          eoc_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_WAIT_CS;
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end

      default: begin
        // A frame that started during the conversion is dropped until cs_n returns high.
        data_d = 1'b0;
        oe_d   = ~cs_sync;
        if (cs_sync) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      sample_q    <= '0;
      result_q    <= '0;
      bit_cnt_q   <= '0;
      addr_sr_q   <= '0;
      last_addr_q <= '0;
      conv_cnt_q  <= '0;
      data_q      <= 1'b0;
      oe_q        <= 1'b0;
      eoc_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      sample_q    <= sample_d;
      result_q    <= result_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_sr_q   <= addr_sr_d;
      last_addr_q <= last_addr_d;
      conv_cnt_q  <= conv_cnt_d;
      data_q      <= data_d;
      oe_q        <= oe_d;
      eoc_q       <= eoc_d;
      done_q      <= done_d;
    end
  end

  assign tlc1543_data    = data_q;
  assign tlc1543_data_oe = oe_q;
  assign tlc1543_eoc     = eoc_q;
  assign conv_done       = done_q;
  assign last_addr       = last_addr_q;

endmodule

// File: tb/tb_tlc1543_adc_model.sv
// Self-checking bench for tlc1543_adc_model: acts as the SPI master and tracks
// the expected result pipeline with a frame-level reference model.
module tb_tlc1543_adc_model;

  localparam int CONV = 1050;

  logic         clk = 1'b0;
  logic         rst;
  logic [109:0] ain_flat;
  logic         t_clk, t_cs_n, t_addr;
  logic         tlc1543_data, tlc1543_data_oe, tlc1543_eoc, conv_done;
  logic [3:0]   last_addr;

  tlc1543_adc_model #(.CONV_CYCLES(CONV), .NUM_AIN(11)) dut (
    .clk(clk), .rst(rst), .ain_flat(ain_flat),
    .tlc1543_clk(t_clk), .tlc1543_cs_n(t_cs_n), .tlc1543_addr(t_addr),
    .tlc1543_data(tlc1543_data), .tlc1543_data_oe(tlc1543_data_oe),
    .tlc1543_eoc(tlc1543_eoc), .conv_done(conv_done), .last_addr(last_addr)
  );

  always #10 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Free-running monitors: eoc-low cycle total, conv_done pulse total, and
  // whether every conv_done coincides with an eoc rise (outside reset).
  int   eocLowTotal = 0;
  int   doneTotal = 0;
  int   syncErr = 0;
  logic prevEoc = 1'b1;
  logic rstSeen = 1'b1;

  always @(posedge clk) rstSeen <= rst;

  always @(negedge clk) begin
    if (!tlc1543_eoc) eocLowTotal++;
    if (conv_done) doneTotal++;
    if (!rstSeen && (conv_done != (tlc1543_eoc && !prevEoc))) syncErr++;
    prevEoc = tlc1543_eoc;
  end

  logic [9:0] ain [11];
  logic [9:0] modelResult;
  logic [3:0] modelLast;

  typedef struct {
    logic [3:0] addr;
    logic [9:0] expData;
    logic [3:0] expLast;
    logic       expConv;
  } vec_t;

  vec_t vecs [11];

  task automatic setChan(input int k, input logic [9:0] v);
    ain[k] = v;
    ain_flat[k*10 +: 10] = v;
  endtask

  function automatic logic [9:0] refValue(input logic [3:0] a);
    if (a <= 4'd10) return ain[a];
    if (a == 4'd11) return 10'h200;
    if (a == 4'd13) return 10'h3FF;
    return 10'h000;
  endfunction

  // A completed frame returns the old result, then commits the new one (unless power-down).
  task automatic modelFrame(input logic [3:0] a);
    modelLast = a;
    if (a != 4'd14) modelResult = refValue(a);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input int nClocks,
                               output logic [9:0] rdata, output logic oeAll,
                               output logic eoc2, output logic eoc3, output logic extraBits);
    logic [3:0] sh;
    sh = addr; rdata = '0; oeAll = 1'b1; eoc2 = 1'b1; eoc3 = 1'b1; extraBits = 1'b0;
    t_cs_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nClocks; i++) begin
      t_addr = sh[3];
      sh = sh << 1;
      if (i < 10) begin
        rdata[9-i] = tlc1543_data;
        oeAll = oeAll & tlc1543_data_oe;
      end else begin
        extraBits = extraBits | tlc1543_data;
      end
      t_clk = 1'b1;
      repeat (5) @(negedge clk);
      t_clk = 1'b0;
      if (i == 9) begin
        repeat (2) @(negedge clk);
        eoc2 = tlc1543_eoc;
        @(negedge clk);
        eoc3 = tlc1543_eoc;
        repeat (2) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
    end
    t_addr = 1'b0;
    t_cs_n = 1'b1;
  endtask

  task automatic waitConv(input int done0, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (doneTotal != done0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic runFrame(input logic [3:0] addr, input logic [9:0] expData,
                          input logic [3:0] expLast, input logic expConv, input string tag);
    logic [9:0] rd;
    logic oe, e2, e3, ex, ok;
    int low0, done0;
    low0 = eocLowTotal; done0 = doneTotal;
    applyStimulus(addr, 10, rd, oe, e2, e3, ex);
    checkOutput($sformatf("%s data", tag), rd, expData);
    checkOutput($sformatf("%s data_oe during shift", tag), oe, 1);
    checkOutput($sformatf("%s eoc 2 cycles after 10th fall", tag), e2, 1);
    checkOutput($sformatf("%s eoc 3 cycles after 10th fall", tag), e3, expConv ? 0 : 1);
    if (expConv) begin
      waitConv(done0, ok);
      checkOutput($sformatf("%s conv_done seen", tag), ok, 1);
      checkOutput($sformatf("%s eoc low cycles", tag), eocLowTotal - low0, CONV);
    end else begin
      repeat (100) @(negedge clk);
      checkOutput($sformatf("%s no conv_done", tag), doneTotal - done0, 0);
      checkOutput($sformatf("%s no eoc low", tag), eocLowTotal - low0, 0);
    end
    repeat (5) @(negedge clk);
    checkOutput($sformatf("%s last_addr", tag), last_addr, expLast);
    checkOutput($sformatf("%s data_oe idle", tag), tlc1543_data_oe, 0);
    checkOutput($sformatf("%s eoc idle", tag), tlc1543_eoc, 1);
  endtask

  task automatic runAbort(input logic [3:0] addr, input int n, input string tag);
    logic [9:0] rd;
    logic oe, e2, e3, ex;
    int low0, done0;
    low0 = eocLowTotal; done0 = doneTotal;
    applyStimulus(addr, n, rd, oe, e2, e3, ex);
    checkOutput($sformatf("%s partial data", tag), int'(rd >> (10 - n)), int'(modelResult >> (10 - n)));
    repeat (50) @(negedge clk);
    checkOutput($sformatf("%s no eoc low", tag), eocLowTotal - low0, 0);
    checkOutput($sformatf("%s no conv_done", tag), doneTotal - done0, 0);
    checkOutput($sformatf("%s last_addr kept", tag), last_addr, modelLast);
    checkOutput($sformatf("%s data_oe released", tag), tlc1543_data_oe, 0);
  endtask

  initial begin
    logic [9:0] rd;
    logic oe, e2, e3, ex, ok;
    int low0, done0;

    rst = 1'b1; t_clk = 1'b0; t_cs_n = 1'b1; t_addr = 1'b0; ain_flat = '0;
    for (int k = 0; k < 11; k++) setChan(k, 10'h000);
    setChan(0, 10'h155);
    setChan(3, 10'h0C3);
    setChan(5, 10'h2A7);
    modelResult = 10'h000; modelLast = 4'd0;

    vecs[0]  = '{4'd0,  10'h000, 4'd0,  1'b1};
    vecs[1]  = '{4'd0,  10'h155, 4'd0,  1'b1};
    vecs[2]  = '{4'd5,  10'h155, 4'd5,  1'b1};
    vecs[3]  = '{4'd13, 10'h2A7, 4'd13, 1'b1};
    vecs[4]  = '{4'd11, 10'h3FF, 4'd11, 1'b1};
    vecs[5]  = '{4'd12, 10'h200, 4'd12, 1'b1};
    vecs[6]  = '{4'd15, 10'h000, 4'd15, 1'b1};
    vecs[7]  = '{4'd5,  10'h000, 4'd5,  1'b1};
    vecs[8]  = '{4'd14, 10'h2A7, 4'd14, 1'b0};
    vecs[9]  = '{4'd3,  10'h2A7, 4'd3,  1'b1};
    vecs[10] = '{4'd0,  10'h0C3, 4'd0,  1'b1};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset eoc", tlc1543_eoc, 1);
    checkOutput("reset data_oe", tlc1543_data_oe, 0);
    checkOutput("reset data", tlc1543_data, 0);
    checkOutput("reset last_addr", last_addr, 0);
    checkOutput("reset conv_done", conv_done, 0);

    for (int v = 0; v < 11; v++) begin
      runFrame(vecs[v].addr, vecs[v].expData, vecs[v].expLast, vecs[v].expConv,
               $sformatf("vec%0d", v));
      modelFrame(vecs[v].addr);
    end

    // Abort after 6 clocks: nothing commits, next frame still sees 0x155.
    runAbort(4'd3, 6, "abort");
    setChan(7, 10'h1E1);
    runFrame(4'd7, 10'h155, 4'd7, 1'b1, "after abort");
    modelFrame(4'd7);

    // Extra clocks beyond the 10th are ignored; data stays low during them.
    setChan(2, 10'h2DB);
    low0 = eocLowTotal; done0 = doneTotal;
    applyStimulus(4'd2, 12, rd, oe, e2, e3, ex);
    checkOutput("extra clocks data", rd, 10'h1E1);
    checkOutput("extra clocks data held low", ex, 0);
    waitConv(done0, ok);
    checkOutput("extra clocks conv_done seen", ok, 1);
    checkOutput("extra clocks eoc low cycles", eocLowTotal - low0, CONV);
    repeat (5) @(negedge clk);
    checkOutput("extra clocks last_addr", last_addr, 2);
    modelFrame(4'd2);

    // Reset 500 cycles into a conversion wipes the result and suppresses conv_done.
    setChan(4, 10'h111);
    low0 = eocLowTotal;
    applyStimulus(4'd4, 10, rd, oe, e2, e3, ex);
    checkOutput("pre-reset frame data", rd, 10'h2DB);
    for (int n = 0; n < 2000 && (eocLowTotal - low0) < 500; n++) @(negedge clk);
    checkOutput("reached 500 conversion cycles", int'((eocLowTotal - low0) >= 500), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-conv reset eoc", tlc1543_eoc, 1);
    checkOutput("mid-conv reset data_oe", tlc1543_data_oe, 0);
    checkOutput("mid-conv reset last_addr", last_addr, 0);
    rst = 1'b0;
    done0 = doneTotal;
    repeat (1200) @(negedge clk);
    checkOutput("mid-conv reset no conv_done", doneTotal - done0, 0);
    modelResult = 10'h000; modelLast = 4'd0;
    runFrame(4'd1, 10'h000, 4'd1, 1'b1, "after reset");
    modelFrame(4'd1);

    for (int r = 0; r < 16; r++) begin
      logic [3:0] a;
      for (int k = 0; k < 11; k++) setChan(k, 10'($urandom_range(0, 1023)));
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        runAbort(a, $urandom_range(1, 9), $sformatf("rand%0d abort", r));
      end else begin
        runFrame(a, modelResult, a, a != 4'd14, $sformatf("rand%0d", r));
        modelFrame(a);
      end
    end

    checkOutput("conv_done aligned with eoc rise", syncErr, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
